// File: rtl/ctrl_flow_sequencer_pkg.sv
// Shared types for the structured-control sequencer.
// Optional stack depth check: CTRL_STACK_OVF_CHECK_EN.
package ctrl_flow_sequencer_pkg;

  localparam int FRAME_W    = 27;
  localparam int ADDR_W     = 18;
  localparam int TAG_W      = 6;
  localparam int BR_DEPTH_W = 8;
  localparam int CS_DEPTH   = 64;

  localparam int TYPE_HI = 26;
  localparam int TYPE_LO = 25;
  localparam int RETU_B  = 24;
  localparam int TAG_HI  = 23;
  localparam int TAG_LO  = 18;
  localparam int ADDR_HI = 17;
  localparam int ADDR_LO = 0;

  typedef enum logic [3:0] {
    OP_BLOCK  = 4'd0,
    OP_LOOP   = 4'd1,
    OP_IF     = 4'd2,
    OP_ELSE   = 4'd3,
    OP_END    = 4'd4,
    OP_BR     = 4'd5,
    OP_BR_IF  = 4'd6,
    OP_CALL   = 4'd7,
    OP_RETURN = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    FT_BLOCK = 2'b00,
    FT_CALL  = 2'b01,
    FT_IF    = 2'b10,
    FT_LOOP  = 2'b11
  } ftype_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UNWIND,
    S_RESOLVE
  } state_e;

endpackage

// File: rtl/ctrl_flow_sequencer_if.sv
// Decoder, control-stack and fetch-redirect signals of the sequencer.
// cs_err exists only with CTRL_STACK_OVF_CHECK_EN.
interface ctrl_flow_sequencer_if;
  import ctrl_flow_sequencer_pkg::*;

  logic                  instr_vld;
  logic                  instr_rdy;
  logic [3:0]            instr_op;
  logic [BR_DEPTH_W-1:0] instr_depth;
  logic                  instr_cond;
  logic                  instr_retu;
  logic [TAG_W-1:0]      instr_sp_tag;
  logic [ADDR_W-1:0]     instr_target;
  logic [ADDR_W-1:0]     instr_alt;
  logic                  cs_shift_vld;
  logic                  cs_push;
  logic                  cs_pop;
  logic                  cs_retu;
  logic                  cs_function_call;
  logic [FRAME_W-1:0]    cs_push_data;
  logic [FRAME_W-1:0]    cs_top_data;
  logic                  cs_left_one;
  logic                  redir_vld;
  logic [ADDR_W-1:0]     redir_pc;
  logic [TAG_W-1:0]      redir_sp_tag;
  logic                  redir_retu;
  logic                  prog_done;
`ifdef CTRL_STACK_OVF_CHECK_EN
  logic                  cs_err;
`endif

  modport slave (
    input  instr_vld, instr_op, instr_depth,
    input  instr_cond, instr_retu, instr_sp_tag,
    input  instr_target, instr_alt,
    input  cs_top_data, cs_left_one,
    output instr_rdy,
    output cs_shift_vld, cs_push, cs_pop,
    output cs_retu, cs_function_call, cs_push_data,
    output redir_vld, redir_pc, redir_sp_tag,
    output redir_retu, prog_done
`ifdef CTRL_STACK_OVF_CHECK_EN
    , output cs_err
`endif
  );

  modport master (
    output instr_vld, instr_op, instr_depth,
    output instr_cond, instr_retu, instr_sp_tag,
    output instr_target, instr_alt,
    output cs_top_data, cs_left_one,
    input  instr_rdy,
    input  cs_shift_vld, cs_push, cs_pop,
    input  cs_retu, cs_function_call, cs_push_data,
    input  redir_vld, redir_pc, redir_sp_tag,
    input  redir_retu, prog_done
`ifdef CTRL_STACK_OVF_CHECK_EN
    , input cs_err
`endif
  );

endinterface

// File: rtl/ctrl_flow_sequencer_frame_pack.sv
// Control-frame assembly and top-frame field extraction.
// Purely combinational.
module ctrl_frame_pack
  import ctrl_flow_sequencer_pkg::*;
(
  input  ftype_e             pk_type,
  input  logic               pk_retu,
  input  logic [TAG_W-1:0]   pk_tag,
  input  logic [ADDR_W-1:0]  pk_addr,
  output logic [FRAME_W-1:0] pk_frame,
  input  logic [FRAME_W-1:0] top_frame,
  output ftype_e             top_type,
  output logic               top_retu,
  output logic [TAG_W-1:0]   top_tag,
  output logic [ADDR_W-1:0]  top_addr
);

  always_comb begin
    pk_frame                  = '0;
    pk_frame[TYPE_HI:TYPE_LO] = pk_type;
    pk_frame[RETU_B]          = pk_retu;
    pk_frame[TAG_HI:TAG_LO]   = pk_tag;
    pk_frame[ADDR_HI:ADDR_LO] = pk_addr;
  end

  assign top_type = ftype_e'(top_frame[TYPE_HI:TYPE_LO]);
  assign top_retu = top_frame[RETU_B];
  assign top_tag  = top_frame[TAG_HI:TAG_LO];
  assign top_addr = top_frame[ADDR_HI:ADDR_LO];

endmodule

// File: rtl/ctrl_flow_sequencer.sv
// Structured-control sequencer driving the control stack and fetch.
// Optional depth check and cs_err: CTRL_STACK_OVF_CHECK_EN.
module ctrl_flow_sequencer
  import ctrl_flow_sequencer_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  ctrl_flow_sequencer_if.slave bus
);

  state_e                state, nxt_state;
  logic [BR_DEPTH_W-1:0] cnt, nxt_cnt;
  op_e                   op;
  logic                  rdy, accept, br_take;
  logic                  resolve, done_set, done_q;
  logic                  push, pop, retu, fcall;

  ftype_e                pk_type;
  logic                  pk_retu;
  logic [TAG_W-1:0]      pk_tag;
  logic [ADDR_W-1:0]     pk_addr;
  logic [FRAME_W-1:0]    pk_frame;
  ftype_e                top_type;
  logic                  top_retu;
  logic [TAG_W-1:0]      top_tag;
  logic [ADDR_W-1:0]     top_addr;

  logic                  rv_nxt, rv_q;
  logic [ADDR_W-1:0]     rpc_nxt, rpc_q;
  logic [TAG_W-1:0]      rtag_nxt, rtag_q;
  logic                  rretu_nxt, rretu_q;

`ifdef CTRL_STACK_OVF_CHECK_EN
  localparam int DW = $clog2(CS_DEPTH) + 1;
  logic [DW-1:0]         dep;
  logic [BR_DEPTH_W-1:0] br_need;
  logic                  br_bad, err_set, err_q;
`endif

  assign op      = op_e'(bus.instr_op);
  assign br_take = (op == OP_BR) |
                   ((op == OP_BR_IF) & bus.instr_cond);
  assign rdy     = (state == S_IDLE) & ~rv_q & ~done_q;
  assign accept  = bus.instr_vld & rdy & ~rst;

  ctrl_frame_pack u_pack (
    .pk_type   (pk_type),
    .pk_retu   (pk_retu),
    .pk_tag    (pk_tag),
    .pk_addr   (pk_addr),
    .pk_frame  (pk_frame),
    .top_frame (bus.cs_top_data),
    .top_type  (top_type),
    .top_retu  (top_retu),
    .top_tag   (top_tag),
    .top_addr  (top_addr)
  );

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    push      = 1'b0;
    pop       = 1'b0;
    retu      = 1'b0;
    fcall     = 1'b0;
    pk_type   = FT_BLOCK;
    pk_retu   = bus.instr_retu;
    pk_tag    = bus.instr_sp_tag;
    pk_addr   = bus.instr_target;
    rv_nxt    = 1'b0;
    rpc_nxt   = '0;
    rtag_nxt  = '0;
    rretu_nxt = 1'b0;
    done_set  = 1'b0;
    resolve   = 1'b0;
    unique case (state)
      S_IDLE: if (accept) begin
        unique case (op)
          OP_BLOCK: push = 1'b1;
          OP_LOOP: begin
            push    = 1'b1;
            pk_type = FT_LOOP;
          end
          OP_IF: begin
            push    = 1'b1;
            pk_type = FT_IF;
            if (!bus.instr_cond) begin
              rv_nxt   = 1'b1;
              rpc_nxt  = bus.instr_alt;
              rtag_nxt = bus.instr_sp_tag;
            end
          end
          OP_CALL: begin
            push     = 1'b1;
            fcall    = 1'b1;
            pk_type  = FT_CALL;
            pk_retu  = 1'b0;
            rv_nxt   = 1'b1;
            rpc_nxt  = bus.instr_alt;
            rtag_nxt = bus.instr_sp_tag;
          end
          OP_ELSE: resolve = 1'b1;
          OP_END: begin
            pop = 1'b1;
            if (bus.cs_left_one) begin
              done_set = 1'b1;
            end else if (top_type == FT_CALL) begin
              rv_nxt    = 1'b1;
              rpc_nxt   = top_addr;
              rtag_nxt  = top_tag;
              rretu_nxt = top_retu;
            end
          end
          OP_RETURN: begin
            pop  = 1'b1;
            retu = 1'b1;
            if (bus.cs_left_one) begin
              done_set = 1'b1;
            end else begin
              rv_nxt    = 1'b1;
              rpc_nxt   = top_addr;
              rtag_nxt  = top_tag;
              rretu_nxt = top_retu;
            end
          end
          OP_BR, OP_BR_IF: if (br_take) begin
            if (bus.instr_depth == '0) begin
              resolve = 1'b1;
            end else begin
              // first unwind pop overlaps the accept cycle
              pop     = 1'b1;
              nxt_cnt = bus.instr_depth - 1'b1;
              nxt_state = (bus.instr_depth == BR_DEPTH_W'(1))
                        ? S_RESOLVE : S_UNWIND;
            end
          end
          default: ;
        endcase
      end
      S_UNWIND: begin
        pop     = 1'b1;
        nxt_cnt = cnt - 1'b1;
        if (cnt == BR_DEPTH_W'(1)) nxt_state = S_RESOLVE;
      end
      S_RESOLVE: begin
        resolve   = 1'b1;
        nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
    if (resolve) begin
      pop       = (top_type != FT_LOOP);
      rv_nxt    = 1'b1;
      rpc_nxt   = top_addr;
      rtag_nxt  = top_tag;
      rretu_nxt = top_retu;
    end
`ifdef CTRL_STACK_OVF_CHECK_EN
    err_set = 1'b0;
    br_need = (op == OP_ELSE) ? '0 : bus.instr_depth;
    br_bad  = accept & (br_take | (op == OP_ELSE)) &
              (int'(br_need) >= int'(dep));
    if ((push && dep == DW'(CS_DEPTH)) ||
        (pop && dep == '0) || br_bad) begin
      push      = 1'b0;
      pop       = 1'b0;
      retu      = 1'b0;
      fcall     = 1'b0;
      rv_nxt    = 1'b0;
      rpc_nxt   = '0;
      rtag_nxt  = '0;
      rretu_nxt = 1'b0;
      done_set  = 1'b0;
      nxt_cnt   = cnt;
      nxt_state = S_IDLE;
      err_set   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      rtag_q  <= '0;
      rretu_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      rv_q    <= rv_nxt;
      rpc_q   <= rpc_nxt;
      rtag_q  <= rtag_nxt;
      rretu_q <= rretu_nxt;
      done_q  <= done_q | done_set;
    end
  end

`ifdef CTRL_STACK_OVF_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dep   <= '0;
      err_q <= 1'b0;
    end else begin
      dep   <= dep + DW'(push) - DW'(pop);
      err_q <= err_q | err_set;
    end
  end

  assign bus.cs_err = err_q;
`endif

  assign bus.instr_rdy        = rdy;
  assign bus.cs_push          = push;
  assign bus.cs_pop           = pop;
  assign bus.cs_retu          = retu;
  assign bus.cs_function_call = fcall;
  assign bus.cs_shift_vld     = push | pop;
  assign bus.cs_push_data     = push ? pk_frame : '0;
  assign bus.redir_vld        = rv_q;
  assign bus.redir_pc         = rpc_q;
  assign bus.redir_sp_tag     = rtag_q;
  assign bus.redir_retu       = rretu_q;
  assign bus.prog_done        = done_q;

endmodule

// File: tb/tb_ctrl_flow_sequencer.sv
// Sequencer bench: bench acts as decoder and control stack,
// checking against a frame-list model of wasm control flow.
module tb_ctrl_flow_sequencer;
  import ctrl_flow_sequencer_pkg::*;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_PUSH = 5'b11000;
  localparam logic [4:0] C_CALL = 5'b11001;
  localparam logic [4:0] C_POP  = 5'b10100;
  localparam logic [4:0] C_RET  = 5'b10110;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [FRAME_W-1:0] stk[$];

  ctrl_flow_sequencer_if bus();

  ctrl_flow_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] mk(
    input logic [1:0] t, input logic r,
    input logic [5:0] tg, input logic [17:0] a);
    return {t, r, tg, a};
  endfunction

  function automatic int call_idx();
    for (int i = stk.size() - 1; i >= 0; i--)
      if (stk[i][26:25] == 2'b01) return i;
    return -1;
  endfunction

  task automatic set_top(input bit ret);
    int i;
    i = ret ? call_idx() : stk.size() - 1;
    bus.cs_top_data = (i >= 0) ? stk[i] : '0;
    bus.cs_left_one = (stk.size() == 1);
  endtask

  task automatic step(input string nm, input logic [4:0] cmd,
                      input logic [26:0] d, input bit rdy_e);
    @(negedge clk);
    chk({nm, ".rdy"}, 32'(bus.instr_rdy), 32'(rdy_e));
    chk({nm, ".cmd"}, 32'({bus.cs_shift_vld, bus.cs_push,
        bus.cs_pop, bus.cs_retu, bus.cs_function_call}),
        32'(cmd));
    chk({nm, ".rv0"}, 32'(bus.redir_vld), 32'd0);
    if (cmd[3])
      chk({nm, ".data"}, 32'(bus.cs_push_data), 32'(d));
    @(posedge clk);
    #1;
  endtask

  task automatic post(input string nm, input bit vld,
                      input logic [17:0] pc, input bit fchk,
                      input logic [5:0] tg, input bit rt,
                      input bit done);
    bus.instr_vld = 1'b0;
    set_top(1'b0);
    @(negedge clk);
    chk({nm, ".rvld"}, 32'(bus.redir_vld), 32'(vld));
    chk({nm, ".done"}, 32'(bus.prog_done), 32'(done));
    chk({nm, ".prdy"}, 32'(bus.instr_rdy), 32'(!vld && !done));
    if (vld) chk({nm, ".pc"}, 32'(bus.redir_pc), 32'(pc));
    if (fchk) begin
      chk({nm, ".tag"}, 32'(bus.redir_sp_tag), 32'(tg));
      chk({nm, ".retu"}, 32'(bus.redir_retu), 32'(rt));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] dp,
                       input bit cond, input bit retu,
                       input logic [5:0] tg,
                       input logic [17:0] tgt, input logic [17:0] alt);
    logic [26:0] f;
    int d, ci;
    bit lo, lp;
    bus.instr_op     = op;
    bus.instr_depth  = dp;
    bus.instr_cond   = cond;
    bus.instr_retu   = retu;
    bus.instr_sp_tag = tg;
    bus.instr_target = tgt;
    bus.instr_alt    = alt;
    bus.instr_vld    = 1'b1;
    set_top(op == OP_RETURN);
    lo = (stk.size() == 1);
    if (op == OP_BLOCK || op == OP_LOOP || op == OP_IF) begin
      f = mk(op == OP_LOOP ? 2'b11 : op == OP_IF ? 2'b10 : 2'b00,
             retu, tg, tgt);
      step("push", C_PUSH, f, 1'b1);
      stk.push_back(f);
      post("push", op == OP_IF && !cond, alt, 1'b0, '0, 1'b0, 1'b0);
    end else if (op == OP_CALL) begin
      f = mk(2'b01, 1'b0, tg, tgt);
      step("call", C_CALL, f, 1'b1);
      stk.push_back(f);
      post("call", 1'b1, alt, 1'b0, '0, 1'b0, 1'b0);
    end else if (op == OP_END) begin
      f = stk[$];
      step("end", C_POP, '0, 1'b1);
      void'(stk.pop_back());
      lp = !lo && f[26:25] == 2'b01;
      post("end", lp, f[17:0], lp, f[23:18], f[24], lo);
    end else if (op == OP_RETURN) begin
      ci = call_idx();
      f = stk[ci];
      step("ret", C_RET, '0, 1'b1);
      while (stk.size() > ci) void'(stk.pop_back());
      post("ret", !lo, f[17:0], !lo, f[23:18], f[24], lo);
    end else if (op == OP_BR || op == OP_BR_IF || op == OP_ELSE) begin
      if (op == OP_BR_IF && !cond) begin
        step("brnop", C_NONE, '0, 1'b1);
        post("brnop", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      end else begin
        d = (op == OP_ELSE) ? 0 : int'(dp);
        for (int i = 0; i < d; i++) begin
          step("unw", C_POP, '0, i == 0);
          void'(stk.pop_back());
          bus.instr_vld = 1'b0;
          set_top(1'b0);
        end
        f = stk[$];
        lp = (f[26:25] == 2'b11);
        step("res", lp ? C_NONE : C_POP, '0, d == 0);
        if (!lp) void'(stk.pop_back());
        post("res", 1'b1, f[17:0], !lp, f[23:18], f[24], 1'b0);
      end
    end else begin
      step("nop", C_NONE, '0, 1'b1);
      post("nop", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_vld = 1'b0;
    bus.instr_op = '0;
    bus.instr_depth = '0;
    bus.instr_cond = 1'b0;
    bus.instr_retu = 1'b0;
    bus.instr_sp_tag = '0;
    bus.instr_target = '0;
    bus.instr_alt = '0;
    bus.cs_top_data = '0;
    bus.cs_left_one = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy", 32'(bus.instr_rdy), 32'd1);
    chk("rst.shift", 32'(bus.cs_shift_vld), 32'd0);
    chk("rst.rvld", 32'(bus.redir_vld), 32'd0);
    chk("rst.pc", 32'(bus.redir_pc), 32'd0);
    chk("rst.done", 32'(bus.prog_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // outer function frame
    issue(OP_CALL, 0, 0, 0, 6'd1, 18'h3FFF0, 18'h100);
    issue(OP_BLOCK, 0, 0, 0, 6'd5, 18'h40, 18'h0);
    issue(OP_END, 0, 0, 0, 6'd0, 18'h0, 18'h0);
    issue(OP_LOOP, 0, 0, 1, 6'd7, 18'h10, 18'h0);
    issue(OP_BLOCK, 0, 0, 0, 6'd8, 18'h50, 18'h0);
    issue(OP_BLOCK, 0, 0, 1, 6'd9, 18'h60, 18'h0);
    issue(OP_BR, 8'd2, 0, 0, 6'd0, 18'h0, 18'h0);
    issue(OP_END, 0, 0, 0, 6'd0, 18'h0, 18'h0);
    issue(OP_CALL, 0, 0, 0, 6'd3, 18'h123, 18'h200);
    issue(OP_BLOCK, 0, 0, 0, 6'd4, 18'h210, 18'h0);
    issue(OP_RETURN, 0, 0, 0, 6'd0, 18'h0, 18'h0);
    issue(OP_IF, 0, 0, 1, 6'd2, 18'h99, 18'h88);
    issue(OP_BR_IF, 8'd0, 0, 0, 6'd0, 18'h0, 18'h0);
    issue(OP_ELSE, 0, 0, 0, 6'd0, 18'h0, 18'h0);
    issue(4'hC, 0, 1, 1, 6'd0, 18'h0, 18'h0);

    for (int n = 0; n < 300; n++) begin
      int sz;
      int k;
      logic [3:0] op;
      logic [7:0] dp;
      sz = stk.size();
      k = $urandom_range(0, 11);
      op = (k >= 9) ? 4'($urandom_range(9, 15)) : 4'(k);
      if ((op <= 4'd2 || op == OP_CALL) && sz >= 30) op = OP_END;
      if (op == OP_END && sz < 2) op = OP_BLOCK;
      if (op == OP_RETURN && call_idx() < 1) op = OP_BLOCK;
      if ((op == OP_ELSE || op == OP_BR || op == OP_BR_IF) && sz < 2)
        op = OP_LOOP;
      dp = 8'($urandom_range(0, (sz >= 2) ? sz - 2 : 0));
      issue(op, dp, 1'($urandom), 1'($urandom), 6'($urandom),
            18'($urandom), 18'($urandom));
    end

    while (stk.size() > 1)
      issue(OP_END, 0, 0, 0, 6'd0, 18'h0, 18'h0);
    issue(OP_END, 0, 0, 0, 6'd0, 18'h0, 18'h0);
    bus.instr_op = OP_BLOCK;
    bus.instr_vld = 1'b1;
    set_top(1'b0);
    repeat (3) step("stuck", C_NONE, '0, 1'b0);
    bus.instr_vld = 1'b0;

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    stk.delete();
    issue(OP_CALL, 0, 0, 0, 6'd1, 18'h3FF00, 18'h300);
    for (int i = 0; i < 5; i++)
      issue(OP_BLOCK, 0, 0, 0, 6'(i), 18'(i + 1), 18'h0);
    bus.instr_op = OP_BR;
    bus.instr_depth = 8'd4;
    bus.instr_vld = 1'b1;
    set_top(1'b0);
    step("rbr", C_POP, '0, 1'b1);
    void'(stk.pop_back());
    bus.instr_vld = 1'b0;
    set_top(1'b0);
    step("rbr", C_POP, '0, 1'b0);
    void'(stk.pop_back());
    set_top(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mrst.shift", 32'(bus.cs_shift_vld), 32'd0);
    chk("mrst.pop", 32'(bus.cs_pop), 32'd0);
    chk("mrst.rvld", 32'(bus.redir_vld), 32'd0);
    chk("mrst.done", 32'(bus.prog_done), 32'd0);
    chk("mrst.rdy", 32'(bus.instr_rdy), 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    issue(OP_BLOCK, 0, 0, 1, 6'd6, 18'h77, 18'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_flow_sequencer.md
Name: ctrl_flow_sequencer

Overview:
- Initiator-side driver for the control stack. Accepts decoded structured-control instructions (block, loop, if, else, end, br, br_if, call, return) from the decoder.
- Emits one push/pop/retu/function_call command per cycle to the control stack and reads back its top frame.
- Issues PC redirects to fetch. Multi-level `br` unwinds one frame per cycle through an FSM.

Parameters:
- FRAME_W, 27, control-frame width: [26:25] type, [24] retu_num, [23:18] sp_tag, [17:0] target address.
- ADDR_W, 18, instruction address width.
- TAG_W, 6, operand-stack pointer tag width.
- BR_DEPTH_W, 8, width of br label depth.
- CS_DEPTH, 64, control stack capacity; used only by the optional check.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr_vld  in  1  decoded control instruction valid
- instr_rdy  out  1  sequencer can accept
- instr_op  in  4  0 BLOCK, 1 LOOP, 2 IF, 3 ELSE, 4 END, 5 BR, 6 BR_IF, 7 CALL, 8 RETURN; others ignored
- instr_depth  in  BR_DEPTH_W  br/br_if label depth
- instr_cond  in  1  if/br_if condition (nonzero = 1)
- instr_retu  in  1  block result count
- instr_sp_tag  in  TAG_W  current operand-stack tag
- instr_target  in  ADDR_W  loop: loop-start; block/if: end address; call: return address
- instr_alt  in  ADDR_W  if: else+1 address, or end address when there is no else; call: callee entry
- cs_shift_vld, cs_push, cs_pop, cs_retu, cs_function_call  out  1 each  stack commands
- cs_push_data  out  FRAME_W  frame to push
- cs_top_data  in  FRAME_W  current top frame (call frame while cs_retu=1)
- cs_left_one  in  1  exactly one frame on the stack
- redir_vld  out  1  one-cycle PC redirect
- redir_pc  out  ADDR_W  redirect target
- redir_sp_tag  out  TAG_W  operand-stack tag to restore
- redir_retu  out  1  result count to keep
- prog_done  out  1  sticky; outermost frame popped
- cs_err  out  1  sticky; present only with the optional feature

Behaviour:
- Reset: state IDLE; instr_rdy=1. All cs_* outputs, redir_*, prog_done and cs_err are 0. Any in-flight unwind is abandoned.
- Acceptance: an instruction is accepted when instr_vld & instr_rdy. Stack commands are combinational in the accept cycle, with cs_shift_vld=1. Redirect outputs are registered: redir_vld pulses in the cycle after the command that produced them.
- BLOCK / LOOP: push {00 or 11, instr_retu, instr_sp_tag, instr_target}. No redirect.
- IF: push {10, ...}. If cond=0, redirect to instr_alt.
- CALL: push {01, 0, instr_sp_tag, instr_target} with cs_function_call=1. Redirect to instr_alt.
- END: pop. Redirect only if the popped frame type is 01; target is its address field, with its sp_tag and retu. If cs_left_one was set, raise prog_done instead of redirecting.
- ELSE: behaves as BR depth 0.
- RETURN: cs_retu=1, cs_pop=1, and redirect to the address of the call frame in cs_top_data. If cs_left_one, raise prog_done instead.
- BR / BR_IF:
  - BR_IF with cond=0: no-op, one cycle.
  - Otherwise load cnt=instr_depth.
  - If cnt=0, go straight to RESOLVE in the same cycle; else enter UNWIND with instr_rdy=0.
- UNWIND: pop one frame per cycle and decrement cnt. When cnt reaches 0, go to RESOLVE.
- RESOLVE: inspect cs_top_data.
  - Type 11 (loop): no pop, shift_vld=0. Redirect to its address.
  - Other types: pop, then redirect to its address with its sp_tag and retu.
  - Return to IDLE.
- FSM transitions: IDLE→UNWIND→RESOLVE→IDLE. The depth-0 path collapses into the accept cycle, so the total latency of br N is N+1 command cycles.
- No new instruction is accepted in the cycle redir_vld is high. The decoder flushes on redirect.
- Once prog_done is set, instr_rdy stays 0 until reset.
- Unknown opcodes are accepted and ignored, with no command.

Optional Feature:
- Macro CTRL_STACK_OVF_CHECK_EN.
- When defined:
  - Track a depth counter of $clog2(CS_DEPTH)+1 bits.
  - Set sticky cs_err on a push when depth==CS_DEPTH, or on a pop or br whose depth exceeds the count.
  - Suppress the offending command (cs_shift_vld=0).
- When undefined: no counter, and cs_err is absent.

Decomposition:
- Shared package/defines:
  - Opcode encodings.
  - Frame-type codes: 00 block, 01 call, 10 if, 11 loop.
  - Frame field bit positions.
  - FRAME_W, ADDR_W and TAG_W defaults.
- One sub-module is natural: ctrl_frame_pack (frame assembly and field extraction, purely combinational). FSM and redirect regs stay in the top.

Test Plan:
- BLOCK(tag=5, target=0x40) then END → push frame {00,0,5,0x40}, then pop; redir_vld never asserted.
- LOOP(target=0x10), BLOCK, BLOCK, then BR depth=2 → pops in 2 consecutive cycles with instr_rdy=0, then no pop; redir_pc=0x10 three cycles after accept.
- CALL(target=0x123, alt=0x200) with inner BLOCK, then RETURN → cs_function_call=1 on push; on return cs_retu=1 and cs_pop=1; redir_pc=0x123.
- IF cond=0 (alt=0x88) → push type 10 and redir_pc=0x88. BR_IF cond=0 → no command, instr_rdy stays 1.
- Single outer CALL frame, END with cs_left_one=1 → prog_done=1, no redirect, instr_rdy stuck at 0.
- rst pulsed mid-UNWIND of br depth=4 → all outputs 0 immediately and state IDLE. With CTRL_STACK_OVF_CHECK_EN, push at depth 64 → cs_err=1 and cs_shift_vld=0.
